// File: rtl/dmem_port_arbiter.sv
// dmem_port_arbiter: shares a dual-port data memory among NREQ requesters,
// granting up to two requests per cycle with rotating priority and aging.
// Ports: clk, rst_n (async, active low)
//   req/req_addr/req_wdata/req_we : per-requester request and payload
//   gnt/rsp_rdata                 : per-requester grant and read word
//   daddr/dwdata/we/drdata        : memory port 0
//   daddr1/dwdata1/we1/drdata1    : memory port 1
//   perf_stall/perf_conflict      : only with DMEM_ARB_PERF_EN defined
module dmem_port_arbiter #(
  parameter  int NREQ     = 3,
  parameter  int MAX_WAIT = 7,
  localparam int WCW      = $clog2(MAX_WAIT + 1)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NREQ-1:0]   req,
  input  logic [NREQ*32-1:0] req_addr,
  input  logic [NREQ*32-1:0] req_wdata,
  input  logic [NREQ*4-1:0] req_we,
  output logic [NREQ-1:0]   gnt,
  output logic [NREQ*32-1:0] rsp_rdata,
  output logic [31:0]       daddr,
  output logic [31:0]       dwdata,
  output logic [3:0]        we,
  input  logic [31:0]       drdata,
  output logic [31:0]       daddr1,
  output logic [31:0]       dwdata1,
  output logic [3:0]        we1,
`ifdef DMEM_ARB_PERF_EN
  output logic [31:0]       perf_stall,
  output logic [31:0]       perf_conflict,
`endif
  input  logic [31:0]       drdata1
);

  localparam int IW = $clog2(NREQ);
  localparam int RW = 5;

  logic [IW-1:0]  r_rr;
  logic [WCW-1:0] r_wait [NREQ];

  logic [31:0]    w_addr [NREQ];
  logic [31:0]    w_wd   [NREQ];
  logic [3:0]     w_we   [NREQ];
  logic [RW-1:0]  w_rank [NREQ];
  logic [NREQ-1:0] w_cf;
  logic           w_p0_vld;
  logic [IW-1:0]  w_p0;
  logic [RW-1:0]  w_p0_rank;
  logic           w_p1_vld;
  logic [IW-1:0]  w_p1;
  logic [RW-1:0]  w_p1_rank;
  logic           w_skip;
  logic [IW-1:0]  w_last;
  logic [IW-1:0]  w_rr_nxt;

  // Rank: starved requesters get 0..NREQ-1 by index, the rest
  // NREQ.. by rotated distance from r_rr. Lower rank wins.
  always_comb begin
    w_p0_vld  = 1'b0;
    w_p0      = '0;
    w_p0_rank = '1;
    w_p1_vld  = 1'b0;
    w_p1      = '0;
    w_p1_rank = '1;
    w_skip    = 1'b0;
    w_cf      = '0;
    for (int i = 0; i < NREQ; i++) begin
      int d;
      w_addr[i] = req_addr[32*i +: 32];
      w_wd[i]   = req_wdata[32*i +: 32];
      w_we[i]   = req_we[4*i +: 4];
      d = i - int'(r_rr);
      if (d < 0) d = d + NREQ;
      if (r_wait[i] == WCW'(MAX_WAIT))
        w_rank[i] = RW'(i);
      else
        w_rank[i] = RW'(NREQ + d);
    end
    for (int i = 0; i < NREQ; i++) begin
      if (req[i] && (!w_p0_vld || w_rank[i] < w_p0_rank)) begin
        w_p0_vld  = 1'b1;
        w_p0      = IW'(i);
        w_p0_rank = w_rank[i];
      end
    end
    // Same word with any write involved must be serialised.
    for (int i = 0; i < NREQ; i++) begin
      w_cf[i] = (w_addr[i][31:2] == w_addr[w_p0][31:2]) &&
                ((w_we[i] != 4'b0) || (w_we[w_p0] != 4'b0));
    end
    for (int i = 0; i < NREQ; i++) begin
      if (w_p0_vld && req[i] && (IW'(i) != w_p0) && !w_cf[i] &&
          (!w_p1_vld || w_rank[i] < w_p1_rank)) begin
        w_p1_vld  = 1'b1;
        w_p1      = IW'(i);
        w_p1_rank = w_rank[i];
      end
    end
    // A conflicting candidate ranked ahead of the port-1 winner
    // was passed over because of the hazard.
    for (int i = 0; i < NREQ; i++) begin
      if (w_p0_vld && req[i] && (IW'(i) != w_p0) && w_cf[i] &&
          (!w_p1_vld || w_rank[i] < w_p1_rank))
        w_skip = 1'b1;
    end
  end

  always_comb begin
    gnt       = '0;
    rsp_rdata = '0;
    daddr     = '0;
    dwdata    = '0;
    we        = '0;
    daddr1    = '0;
    dwdata1   = '0;
    we1       = '0;
    if (rst_n) begin
      if (w_p0_vld) begin
        daddr  = w_addr[w_p0];
        dwdata = w_wd[w_p0];
        we     = w_we[w_p0];
      end
      if (w_p1_vld) begin
        daddr1  = w_addr[w_p1];
        dwdata1 = w_wd[w_p1];
        we1     = w_we[w_p1];
      end
      for (int i = 0; i < NREQ; i++) begin
        if (w_p0_vld && IW'(i) == w_p0) begin
          gnt[i] = 1'b1;
          rsp_rdata[32*i +: 32] = drdata;
        end else if (w_p1_vld && IW'(i) == w_p1) begin
          gnt[i] = 1'b1;
          rsp_rdata[32*i +: 32] = drdata1;
        end
      end
    end
  end

  always_comb begin
    w_last   = w_p1_vld ? w_p1 : w_p0;
    w_rr_nxt = (w_last == IW'(NREQ - 1)) ? '0 : w_last + 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rr <= '0;
      for (int i = 0; i < NREQ; i++) r_wait[i] <= '0;
    end else begin
      if (|gnt) r_rr <= w_rr_nxt;
      for (int i = 0; i < NREQ; i++) begin
        if (req[i] && !gnt[i]) begin
          if (r_wait[i] != WCW'(MAX_WAIT))
            r_wait[i] <= r_wait[i] + 1'b1;
        end else begin
          r_wait[i] <= '0;
        end
      end
    end
  end

`ifdef DMEM_ARB_PERF_EN
  logic [31:0] r_perf_stall;
  logic [31:0] r_perf_conflict;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_perf_stall    <= '0;
      r_perf_conflict <= '0;
    end else begin
      if (|(req & ~gnt)) r_perf_stall <= r_perf_stall + 32'd1;
      if (w_skip) r_perf_conflict <= r_perf_conflict + 32'd1;
    end
  end

  assign perf_stall    = r_perf_stall;
  assign perf_conflict = r_perf_conflict;
`else
  logic w_unused;
  assign w_unused = w_skip;
`endif

endmodule
